// File: rtl/i2s_receiver.sv
// Slave-mode I2S receiver: BCLK, LRCLK and SDATA are oversampled in the clk domain
// and deserialized into stereo sample pairs with lock and short-slot detection.
module i2s_receiver #(
    parameter int BITS_PER_SAMPLE = 16,
    parameter int I2S_STANDARD    = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i2s_bclk,
    input  logic                       i2s_lrclk,
    input  logic                       i2s_sdata,
    output logic [BITS_PER_SAMPLE-1:0] left_sample,
    output logic [BITS_PER_SAMPLE-1:0] right_sample,
    output logic                       sample_valid,
    output logic                       frame_error,
    output logic                       locked
);

    localparam int CW = $clog2(BITS_PER_SAMPLE + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] FULL    = CW'(BITS_PER_SAMPLE);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {
        WAIT_SYNC = 1'b0,
        CAPTURE   = 1'b1
    } state_t;

    state_t                     state_r, state_nxt_s;
    logic [SYNC_STAGES-1:0]     bclk_sync_r, lr_sync_r, sd_sync_r;
    logic                       bclk_prev_r, lr_prev_r, lr_seen_r;
    logic                       bclk_s, lr_s, sd_s;
    logic                       bclk_rise_s, lr_edge_s, timeout_s;
    logic [WW-1:0]              wd_r;
    logic [CW-1:0]              cnt_r, cnt_nxt_s;
    logic [BITS_PER_SAMPLE-1:0] shreg_r, shreg_nxt_s, left_hold_r;
    logic                       chan_r, chan_nxt_s;
    logic                       in_slot_r, in_slot_nxt_s;
    logic                       pend_r, pend_nxt_s;
    logic                       step_s, commit_s, commit_left_s, short_s;
    logic                       left_held_r;

    // Pin synchronizers; all three share depth so they stay mutually aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync_r <= {SYNC_STAGES{1'b0}};
            lr_sync_r   <= {SYNC_STAGES{1'b0}};
            sd_sync_r   <= {SYNC_STAGES{1'b0}};
            bclk_prev_r <= 1'b0;
        end else begin
            bclk_sync_r <= {bclk_sync_r[SYNC_STAGES-2:0], i2s_bclk};
            lr_sync_r   <= {lr_sync_r[SYNC_STAGES-2:0], i2s_lrclk};
            sd_sync_r   <= {sd_sync_r[SYNC_STAGES-2:0], i2s_sdata};
            bclk_prev_r <= bclk_s;
        end
    end

    assign bclk_s      = bclk_sync_r[SYNC_STAGES-1];
    assign lr_s        = lr_sync_r[SYNC_STAGES-1];
    assign sd_s        = sd_sync_r[SYNC_STAGES-1];
    assign bclk_rise_s = bclk_s & ~bclk_prev_r;
    // lr_seen_r keeps the first edge after reset from faking an LR transition
    assign lr_edge_s   = bclk_rise_s & lr_seen_r & (lr_s != lr_prev_r);
    assign timeout_s   = ~bclk_rise_s & (wd_r == WD_LAST);

    // LRCLK history and BCLK-activity watchdog
    always_ff @(posedge clk) begin
        if (reset) begin
            lr_prev_r <= 1'b0;
            lr_seen_r <= 1'b0;
            wd_r      <= {WW{1'b0}};
        end else if (bclk_rise_s) begin
            lr_prev_r <= lr_s;
            lr_seen_r <= 1'b1;
            wd_r      <= {WW{1'b0}};
        end else if (wd_r != WD_MAX) begin
            wd_r      <= wd_r + WW'(1);
        end else begin
            wd_r      <= wd_r;
        end
    end

    // Sync state next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            WAIT_SYNC: begin
                if (lr_edge_s) state_nxt_s = CAPTURE;
                else           state_nxt_s = WAIT_SYNC;
            end
            CAPTURE: begin
                if (timeout_s) state_nxt_s = WAIT_SYNC;
                else           state_nxt_s = CAPTURE;
            end
            default: state_nxt_s = WAIT_SYNC;
        endcase
    end

    // Slot tracking: in standard mode the edge-N bit is stored before the new slot is armed
    always_comb begin
        cnt_nxt_s     = cnt_r;
        shreg_nxt_s   = shreg_r;
        chan_nxt_s    = chan_r;
        in_slot_nxt_s = in_slot_r;
        pend_nxt_s    = pend_r;
        step_s        = 1'b0;
        commit_s      = 1'b0;
        commit_left_s = 1'b0;
        short_s       = 1'b0;
        if (timeout_s) begin
            cnt_nxt_s     = {CW{1'b0}};
            in_slot_nxt_s = 1'b0;
            pend_nxt_s    = 1'b0;
        end else if (bclk_rise_s && ((state_r == CAPTURE) || lr_edge_s)) begin
            if (I2S_STANDARD != 0) begin
                if (pend_r) begin
                    shreg_nxt_s   = {shreg_r[BITS_PER_SAMPLE-2:0], sd_s};
                    cnt_nxt_s     = CW'(1);
                    in_slot_nxt_s = 1'b1;
                    pend_nxt_s    = 1'b0;
                    step_s        = 1'b1;
                end else if (in_slot_r && (cnt_r != FULL)) begin
                    shreg_nxt_s   = {shreg_r[BITS_PER_SAMPLE-2:0], sd_s};
                    cnt_nxt_s     = cnt_r + CW'(1);
                    step_s        = 1'b1;
                end else begin
                    step_s        = 1'b0;
                end
                commit_s      = step_s && (cnt_nxt_s == FULL);
                commit_left_s = ~chan_r;
                if (lr_edge_s) begin
                    short_s       = in_slot_nxt_s && (cnt_nxt_s != FULL);
                    pend_nxt_s    = 1'b1;
                    in_slot_nxt_s = 1'b0;
                    chan_nxt_s    = lr_s;
                end else begin
                    short_s       = 1'b0;
                end
            end else begin
                if (lr_edge_s) begin
                    short_s       = in_slot_r && (cnt_r != FULL);
                    shreg_nxt_s   = {shreg_r[BITS_PER_SAMPLE-2:0], sd_s};
                    cnt_nxt_s     = CW'(1);
                    in_slot_nxt_s = 1'b1;
                    chan_nxt_s    = lr_s;
                    step_s        = 1'b1;
                end else if (in_slot_r && (cnt_r != FULL)) begin
                    shreg_nxt_s   = {shreg_r[BITS_PER_SAMPLE-2:0], sd_s};
                    cnt_nxt_s     = cnt_r + CW'(1);
                    step_s        = 1'b1;
                end else begin
                    step_s        = 1'b0;
                end
                commit_s      = step_s && (cnt_nxt_s == FULL);
                commit_left_s = ~chan_nxt_s;
            end
        end else begin
            step_s = 1'b0;
        end
    end

    // State and slot registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= WAIT_SYNC;
            cnt_r     <= {CW{1'b0}};
            shreg_r   <= {BITS_PER_SAMPLE{1'b0}};
            chan_r    <= 1'b0;
            in_slot_r <= 1'b0;
            pend_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            shreg_r   <= shreg_nxt_s;
            chan_r    <= chan_nxt_s;
            in_slot_r <= in_slot_nxt_s;
            pend_r    <= pend_nxt_s;
        end
    end

    // Word commit, pairing and status outputs; a right word needs a held left word
    always_ff @(posedge clk) begin
        if (reset) begin
            left_sample  <= {BITS_PER_SAMPLE{1'b0}};
            right_sample <= {BITS_PER_SAMPLE{1'b0}};
            left_hold_r  <= {BITS_PER_SAMPLE{1'b0}};
            left_held_r  <= 1'b0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            if (timeout_s) begin
                locked      <= 1'b0;
                left_held_r <= 1'b0;
            end else if (short_s) begin
                frame_error <= 1'b1;
                locked      <= 1'b0;
                left_held_r <= 1'b0;
            end else if (commit_s && commit_left_s) begin
                left_hold_r <= shreg_nxt_s;
                left_held_r <= 1'b1;
            end else if (commit_s && left_held_r) begin
                left_sample  <= left_hold_r;
                right_sample <= shreg_nxt_s;
                sample_valid <= 1'b1;
                locked       <= 1'b1;
                left_held_r  <= 1'b0;
            end else begin
                left_held_r <= left_held_r;
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: one standard-mode and one left-justified instance
// share the same pins; each task checks its own scenario against hand-computed values.
module tb_i2s_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        bclk, lrclk, sdata;
    logic [15:0] s_left, s_right, j_left, j_right;
    logic        s_valid, s_err, s_locked, j_valid, j_err, j_locked;

    int n_tests = 0;
    int n_fail  = 0;
    int sv_cnt = 0, se_cnt = 0, both_cnt = 0, jv_cnt = 0, je_cnt = 0;
    logic [15:0] s_l_last = 16'h0, s_r_last = 16'h0, j_l_last = 16'h0, j_r_last = 16'h0;
    logic dbit;

    i2s_receiver dut_std (
        .clk(clk), .reset(reset), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
        .left_sample(s_left), .right_sample(s_right), .sample_valid(s_valid),
        .frame_error(s_err), .locked(s_locked)
    );

    i2s_receiver #(.I2S_STANDARD(0)) dut_lj (
        .clk(clk), .reset(reset), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
        .left_sample(j_left), .right_sample(j_right), .sample_valid(j_valid),
        .frame_error(j_err), .locked(j_locked)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (s_valid) begin
            sv_cnt   <= sv_cnt + 1;
            s_l_last <= s_left;
            s_r_last <= s_right;
        end
        if (s_err) se_cnt <= se_cnt + 1;
        if (s_valid && s_err) both_cnt <= both_cnt + 1;
        if (j_valid) begin
            jv_cnt   <= jv_cnt + 1;
            j_l_last <= j_left;
            j_r_last <= j_right;
        end
        if (j_err) je_cnt <= je_cnt + 1;
    end

    task automatic bclk_cycle(input logic lr, input logic d);
        bclk = 1'b0; lrclk = lr; sdata = d;
        repeat (4) @(posedge clk);
        bclk = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    // std=1 delays data one BCLK behind LRCLK (I2S framing); std=0 is left-justified
    task automatic send_slot(input logic lr, input logic [31:0] bits, input int n, input bit std);
        for (int i = 0; i < n; i++) begin
            if (std) begin
                bclk_cycle(lr, dbit);
                dbit = bits[31-i];
            end else begin
                bclk_cycle(lr, bits[31-i]);
            end
        end
    endtask

    task automatic edge_bit();
        bclk_cycle(1'b0, dbit);
        dbit = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bclk = 1'b0;
        repeat (1100) @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; bclk = 1'b0; lrclk = 1'b1; sdata = 1'b0; dbit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (s_left !== 16'h0) begin n_fail++; $display("FAIL rst_left: got %h want 0000", s_left); end
        n_tests++; if (s_right !== 16'h0) begin n_fail++; $display("FAIL rst_right: got %h want 0000", s_right); end
        n_tests++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", s_valid); end
        n_tests++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", s_err); end
        n_tests++; if (s_locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %b want 0", s_locked); end
        n_tests++; if (j_locked !== 1'b0) begin n_fail++; $display("FAIL rst_lj_locked: got %b want 0", j_locked); end
        reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_std_frames();
        int bv, be;
        bv = sv_cnt; be = se_cnt;
        send_slot(1'b1, 32'h0, 16, 1'b1);
        for (int f = 0; f < 4; f++) begin
            send_slot(1'b0, {16'hA5C3, 16'h0}, 16, 1'b1);
            send_slot(1'b1, {16'h5A3C, 16'h0}, 16, 1'b1);
            #1;
            if (f == 0) begin
                n_tests++; if (s_locked !== 1'b0) begin n_fail++; $display("FAIL std_unlocked_before_lsb: got %b want 0", s_locked); end
                n_tests++; if (sv_cnt - bv !== 0) begin n_fail++; $display("FAIL std_no_early_valid: got %0d want 0", sv_cnt - bv); end
            end
            if (f == 1) begin
                n_tests++; if (s_locked !== 1'b1) begin n_fail++; $display("FAIL std_locked_after_frame1: got %b want 1", s_locked); end
            end
        end
        edge_bit();
        n_tests++; if (sv_cnt - bv !== 4) begin n_fail++; $display("FAIL std_valid_count: got %0d want 4", sv_cnt - bv); end
        n_tests++; if (s_l_last !== 16'hA5C3) begin n_fail++; $display("FAIL std_left: got %h want a5c3", s_l_last); end
        n_tests++; if (s_r_last !== 16'h5A3C) begin n_fail++; $display("FAIL std_right: got %h want 5a3c", s_r_last); end
        n_tests++; if (se_cnt - be !== 0) begin n_fail++; $display("FAIL std_no_error: got %0d want 0", se_cnt - be); end
        n_tests++; if (s_left !== 16'hA5C3) begin n_fail++; $display("FAIL std_left_hold: got %h want a5c3", s_left); end
        idle_bus();
    endtask

    task automatic test_wide_slots();
        int bv, be;
        bv = sv_cnt; be = se_cnt;
        send_slot(1'b1, 32'h0, 32, 1'b1);
        for (int f = 0; f < 2; f++) begin
            send_slot(1'b0, {16'h8001, 16'hD2B7}, 32, 1'b1);
            send_slot(1'b1, {16'h7FFE, 16'h4C1F}, 32, 1'b1);
        end
        edge_bit();
        n_tests++; if (sv_cnt - bv !== 2) begin n_fail++; $display("FAIL wide_valid_count: got %0d want 2", sv_cnt - bv); end
        n_tests++; if (s_l_last !== 16'h8001) begin n_fail++; $display("FAIL wide_left: got %h want 8001", s_l_last); end
        n_tests++; if (s_r_last !== 16'h7FFE) begin n_fail++; $display("FAIL wide_right: got %h want 7ffe", s_r_last); end
        n_tests++; if (se_cnt - be !== 0) begin n_fail++; $display("FAIL wide_no_error: got %0d want 0", se_cnt - be); end
        idle_bus();
    endtask

    task automatic test_left_justified();
        int bv, be, jbv, jbe;
        bv = sv_cnt; be = se_cnt; jbv = jv_cnt; jbe = je_cnt;
        send_slot(1'b1, 32'h0, 16, 1'b0);
        for (int f = 0; f < 2; f++) begin
            send_slot(1'b0, {16'h1234, 16'h0}, 16, 1'b0);
            send_slot(1'b1, {16'hFEDC, 16'h0}, 16, 1'b0);
        end
        bclk_cycle(1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        n_tests++; if (jv_cnt - jbv !== 2) begin n_fail++; $display("FAIL lj_valid_count: got %0d want 2", jv_cnt - jbv); end
        n_tests++; if (j_l_last !== 16'h1234) begin n_fail++; $display("FAIL lj_left: got %h want 1234", j_l_last); end
        n_tests++; if (j_r_last !== 16'hFEDC) begin n_fail++; $display("FAIL lj_right: got %h want fedc", j_r_last); end
        n_tests++; if (je_cnt - jbe !== 0) begin n_fail++; $display("FAIL lj_no_error: got %0d want 0", je_cnt - jbe); end
        n_tests++; if (sv_cnt - bv !== 2) begin n_fail++; $display("FAIL lj_as_std_count: got %0d want 2", sv_cnt - bv); end
        n_tests++; if (s_l_last !== 16'h2469) begin n_fail++; $display("FAIL lj_as_std_left: got %h want 2469", s_l_last); end
        n_tests++; if (s_r_last !== 16'hFDB8) begin n_fail++; $display("FAIL lj_as_std_right: got %h want fdb8", s_r_last); end
        n_tests++; if (se_cnt - be !== 0) begin n_fail++; $display("FAIL lj_as_std_error: got %0d want 0", se_cnt - be); end
        idle_bus();
    endtask

    task automatic test_short_slot();
        int bv, be;
        bv = sv_cnt; be = se_cnt;
        send_slot(1'b1, 32'h0, 16, 1'b1);
        send_slot(1'b0, {16'hA5C3, 16'h0}, 16, 1'b1);
        send_slot(1'b1, {16'h5A3C, 16'h0}, 16, 1'b1);
        send_slot(1'b0, {16'h1111, 16'h0}, 10, 1'b1);
        send_slot(1'b1, {16'h2222, 16'h0}, 16, 1'b1);
        #1;
        n_tests++; if (se_cnt - be !== 1) begin n_fail++; $display("FAIL short_error_pulse: got %0d want 1", se_cnt - be); end
        n_tests++; if (s_locked !== 1'b0) begin n_fail++; $display("FAIL short_locked_drop: got %b want 0", s_locked); end
        n_tests++; if (sv_cnt - bv !== 1) begin n_fail++; $display("FAIL short_valid_before: got %0d want 1", sv_cnt - bv); end
        send_slot(1'b0, {16'h1357, 16'h0}, 16, 1'b1);
        send_slot(1'b1, {16'h9BDF, 16'h0}, 16, 1'b1);
        edge_bit();
        n_tests++; if (sv_cnt - bv !== 2) begin n_fail++; $display("FAIL short_recover_count: got %0d want 2", sv_cnt - bv); end
        n_tests++; if (s_l_last !== 16'h1357) begin n_fail++; $display("FAIL short_recover_left: got %h want 1357", s_l_last); end
        n_tests++; if (s_r_last !== 16'h9BDF) begin n_fail++; $display("FAIL short_recover_right: got %h want 9bdf", s_r_last); end
        n_tests++; if (s_locked !== 1'b1) begin n_fail++; $display("FAIL short_relock: got %b want 1", s_locked); end
        n_tests++; if (se_cnt - be !== 1) begin n_fail++; $display("FAIL short_single_error: got %0d want 1", se_cnt - be); end
        n_tests++; if (both_cnt !== 0) begin n_fail++; $display("FAIL pulse_overlap: got %0d want 0", both_cnt); end
        idle_bus();
    endtask

    task automatic test_timeout();
        int bv, be, n;
        send_slot(1'b1, 32'h0, 16, 1'b1);
        send_slot(1'b0, {16'hA5C3, 16'h0}, 16, 1'b1);
        send_slot(1'b1, {16'h5A3C, 16'h0}, 16, 1'b1);
        edge_bit();
        n_tests++; if (s_locked !== 1'b1) begin n_fail++; $display("FAIL to_locked_before: got %b want 1", s_locked); end
        be = se_cnt;
        bclk = 1'b0;
        n = 0;
        while (s_locked === 1'b1 && n < 1200) begin
            @(posedge clk); #1;
            n++;
        end
        n_tests++; if (s_locked !== 1'b0) begin n_fail++; $display("FAIL to_locked_fall: got %b want 0", s_locked); end
        n_tests++; if (n < 1005 || n > 1035) begin n_fail++; $display("FAIL to_fall_cycle: got %0d want 1005..1035", n); end
        repeat (80) @(posedge clk);
        #1;
        n_tests++; if (se_cnt - be !== 0) begin n_fail++; $display("FAIL to_no_error: got %0d want 0", se_cnt - be); end
        bv = sv_cnt;
        send_slot(1'b1, 32'h0, 16, 1'b1);
        send_slot(1'b0, {16'h9ABC, 16'h0}, 16, 1'b1);
        send_slot(1'b1, {16'hDEF0, 16'h0}, 16, 1'b1);
        edge_bit();
        n_tests++; if (sv_cnt - bv !== 1) begin n_fail++; $display("FAIL to_resume_count: got %0d want 1", sv_cnt - bv); end
        n_tests++; if (s_l_last !== 16'h9ABC) begin n_fail++; $display("FAIL to_resume_left: got %h want 9abc", s_l_last); end
        n_tests++; if (s_r_last !== 16'hDEF0) begin n_fail++; $display("FAIL to_resume_right: got %h want def0", s_r_last); end
        n_tests++; if (s_locked !== 1'b1) begin n_fail++; $display("FAIL to_relock: got %b want 1", s_locked); end
        idle_bus();
    endtask

    task automatic test_reset_midframe();
        int bv, be;
        send_slot(1'b1, 32'h0, 16, 1'b1);
        send_slot(1'b0, {16'h0F0F, 16'h0}, 16, 1'b1);
        send_slot(1'b1, {16'hF0F0, 16'h0}, 16, 1'b1);
        send_slot(1'b0, {16'h4321, 16'h0}, 8, 1'b1);
        @(posedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (s_left !== 16'h0) begin n_fail++; $display("FAIL mid_rst_left: got %h want 0000", s_left); end
        n_tests++; if (s_right !== 16'h0) begin n_fail++; $display("FAIL mid_rst_right: got %h want 0000", s_right); end
        n_tests++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", s_valid); end
        n_tests++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err: got %b want 0", s_err); end
        n_tests++; if (s_locked !== 1'b0) begin n_fail++; $display("FAIL mid_rst_locked: got %b want 0", s_locked); end
        reset = 1'b0;
        bv = sv_cnt; be = se_cnt;
        send_slot(1'b0, {8'h21, 24'h0}, 8, 1'b1);
        send_slot(1'b1, {16'h8765, 16'h0}, 16, 1'b1);
        send_slot(1'b0, {16'hCAFE, 16'h0}, 16, 1'b1);
        #1;
        n_tests++; if (sv_cnt - bv !== 0) begin n_fail++; $display("FAIL mid_partial_discard: got %0d want 0", sv_cnt - bv); end
        send_slot(1'b1, {16'hBEEF, 16'h0}, 16, 1'b1);
        edge_bit();
        n_tests++; if (sv_cnt - bv !== 1) begin n_fail++; $display("FAIL mid_first_pair_count: got %0d want 1", sv_cnt - bv); end
        n_tests++; if (s_l_last !== 16'hCAFE) begin n_fail++; $display("FAIL mid_left: got %h want cafe", s_l_last); end
        n_tests++; if (s_r_last !== 16'hBEEF) begin n_fail++; $display("FAIL mid_right: got %h want beef", s_r_last); end
        n_tests++; if (se_cnt - be !== 0) begin n_fail++; $display("FAIL mid_no_error: got %0d want 0", se_cnt - be); end
        n_tests++; if (s_locked !== 1'b1) begin n_fail++; $display("FAIL mid_relock: got %b want 1", s_locked); end
    endtask

    initial begin
        test_reset();
        test_std_frames();
        test_wide_slots();
        test_left_justified();
        test_short_slot();
        test_timeout();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
